// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between the CPU LSU (m0) and DMA/debug (m1).
// Rev 1.0. Optional round-robin arbitration: define DATA_MEM_ARB_ROUND_ROBIN_EN.
`default_nettype none

module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           starve;
  logic           m0_prio;
  logic           rvalid0_q;
  logic           rvalid1_q;

  assign starve = m1_req && (wait_cnt == WCW'(MAX_WAIT));

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  // last_winner = 1 means m1 was granted most recently, so m0 takes the next tie
  logic last_winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= 1'b1;
    end else if (m0_gnt) begin
      last_winner <= 1'b0;
    end else if (m1_gnt) begin
      last_winner <= 1'b1;
    end
  end

  assign m0_prio = last_winner;
`else
  assign m0_prio = 1'b1;
`endif

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    state_nxt = state;
    if (!rst) begin
      case (state)
        ARB: begin
          if (starve) begin
            m1_gnt = 1'b1;
          end else if (m0_req && (m0_prio || !m1_req)) begin
            m0_gnt = 1'b1;
          end else if (m1_req) begin
            m1_gnt = 1'b1;
          end
          if (m1_gnt && m1_lock) begin
            state_nxt = LOCK1;
          end
        end
        LOCK1: begin
          m1_gnt = m1_req;
          if (!m1_req || !m1_lock) begin
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_comb begin
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    if (m0_gnt) begin
      mem_write_en = m0_we;
      mem_read_en  = ~m0_we;
      mem_addr     = m0_addr;
      mem_data_in  = m0_wdata;
    end else if (m1_gnt) begin
      mem_write_en = m1_we;
      mem_read_en  = ~m1_we;
      mem_addr     = m1_addr;
      mem_data_in  = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      wait_cnt  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rvalid0_q <= m0_gnt & ~m0_we;
      rvalid1_q <= m1_gnt & ~m1_we;
      if (m1_gnt || !m1_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WCW'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end
    end
  end

  // Masking with rst hides a read granted just before reset was asserted
  assign m0_rvalid = rvalid0_q & ~rst;
  assign m1_rvalid = rvalid1_q & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_data_out : '0;
  assign m1_rdata  = m1_rvalid ? mem_data_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of data_mem_arbiter (default fixed-priority build, MAX_WAIT=4).
`default_nettype none

module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [7:0]  m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [15:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [7:0]  m1_rdata;
  logic        mem_write_en, mem_read_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .MAX_WAIT  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_lock     (m1_lock),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .mem_write_en(mem_write_en),
    .mem_read_en (mem_read_en),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one-cycle registered read
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_data_in;
    if (mem_read_en) mem_data_out <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
    check("rd_wr_exclusive", {31'd0, mem_read_en & mem_write_en}, 32'd0);
  endtask

  task automatic set0(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic req, input logic we, input logic lk, input logic [15:0] a,
                      input logic [7:0] d);
    m1_req = req; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    set1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    tick();
    // Reset: requests are ignored and nothing is driven to memory
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    settle();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_read_en", mem_read_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    tick();
    rst = 1'b0;

    // Single write then read
    set0(1'b1, 1'b1, 16'h0010, 8'hA5);
    settle();
    check("wr_m0_gnt", m0_gnt, 1);
    check("wr_write_en", mem_write_en, 1);
    check("wr_addr", mem_addr, 16'h0010);
    check("wr_data", mem_data_in, 8'hA5);
    tick();
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    settle();
    check("rd_m0_gnt", m0_gnt, 1);
    check("rd_read_en", mem_read_en, 1);
    check("rd_no_rvalid_after_write", m0_rvalid, 0);
    tick();
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    settle();
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 8'hA5);
    check("rd_m1_rvalid", m1_rvalid, 0);
    check("idle_read_en", mem_read_en, 0);
    tick();
    settle();
    check("rd_rvalid_drops", m0_rvalid, 0);
    check("rd_rdata_zero", m0_rdata, 0);

    // Preload 0x3C at 0x0020 through m1
    set1(1'b1, 1'b1, 1'b0, 16'h0020, 8'h3C);
    settle();
    check("pre_m1_gnt", m1_gnt, 1);
    tick();

    // Contention: m0 wins four times, then m1 is forced through
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    set1(1'b1, 1'b0, 1'b0, 16'h0020, 8'h00);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("cont_m0_gnt", m0_gnt, 1);
      check("cont_m1_held", m1_gnt, 0);
      tick();
    end
    settle();
    check("cont_m0_denied", m0_gnt, 0);
    check("cont_m1_forced", m1_gnt, 1);
    check("cont_addr", mem_addr, 16'h0020);
    check("cont_m0_rdata", m0_rdata, 8'hA5);
    tick();
    settle();
    check("cont_m1_rvalid", m1_rvalid, 1);
    check("cont_m1_rdata", m1_rdata, 8'h3C);
    check("cont_m0_rvalid_gap", m0_rvalid, 0);
    // Counter restarted from 0: another four m0 wins before m1
    for (int i = 0; i < 4; i++) begin
      if (i != 0) settle();
      check("cont2_m0_gnt", m0_gnt, 1);
      tick();
    end
    settle();
    check("cont2_m1_forced", m1_gnt, 1);
    tick();
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    set1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    settle();
    check("cont2_m1_rvalid", m1_rvalid, 1);
    tick();

    // Lock burst while m0 keeps requesting; first beat arrives via starvation override
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    set1(1'b1, 1'b1, 1'b1, 16'h0100, 8'h01);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("lk_wait_m0_gnt", m0_gnt, 1);
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      set1(1'b1, 1'b1, (b != 3), 16'h0100 + 16'(b), 8'(b + 1));
      settle();
      check("lk_beat_m1_gnt", m1_gnt, 1);
      check("lk_beat_m0_blocked", m0_gnt, 0);
      check("lk_beat_addr", mem_addr, 32'h0100 + b);
      check("lk_beat_data", mem_data_in, b + 1);
      tick();
    end
    set1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    for (int b = 0; b < 4; b++) begin
      set0(1'b1, 1'b0, 16'h0100 + 16'(b), 8'h00);
      settle();
      check("rb_m0_gnt", m0_gnt, 1);
      if (b != 0) check("rb_rdata", m0_rdata, b);
      tick();
    end
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    settle();
    check("rb_last_rvalid", m0_rvalid, 1);
    check("rb_last_rdata", m0_rdata, 8'h04);
    tick();

    // Lock released by dropping m1_req: m0 still blocked that cycle, granted the next
    set1(1'b1, 1'b0, 1'b1, 16'h0020, 8'h00);
    settle();
    check("rel_m1_lock_gnt", m1_gnt, 1);
    tick();
    set1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    settle();
    check("rel_m0_blocked", m0_gnt, 0);
    check("rel_m1_rvalid", m1_rvalid, 1);
    tick();
    settle();
    check("rel_m0_gnt", m0_gnt, 1);
    tick();
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    tick();

    // Reset one cycle after a granted read
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    settle();
    check("rr_m0_gnt", m0_gnt, 1);
    tick();
    rst = 1'b1;
    settle();
    check("rr_rvalid_in_rst", m0_rvalid, 0);
    check("rr_gnt_in_rst", m0_gnt, 0);
    check("rr_read_en_in_rst", mem_read_en, 0);
    check("rr_rdata_in_rst", m0_rdata, 0);
    tick();
    rst = 1'b0;
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    settle();
    check("rr_rvalid_after_rst", m0_rvalid, 0);
    tick();

    // Reset drops an active lock
    set1(1'b1, 1'b0, 1'b1, 16'h0020, 8'h00);
    settle();
    check("rl_m1_lock_gnt", m1_gnt, 1);
    tick();
    rst = 1'b1;
    settle();
    check("rl_m1_gnt_in_rst", m1_gnt, 0);
    tick();
    rst = 1'b0;
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    settle();
    check("rl_m0_wins_after_rst", m0_gnt, 1);
    check("rl_m1_denied", m1_gnt, 0);
    tick();
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    set1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    tick();

    // Interleaved alternation
    set0(1'b1, 1'b0, 16'h0010, 8'h00);
    settle();
    check("il_m0_gnt", m0_gnt, 1);
    tick();
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    set1(1'b1, 1'b1, 1'b0, 16'h0030, 8'h55);
    settle();
    check("il_m1_gnt", m1_gnt, 1);
    check("il_m1_write_en", mem_write_en, 1);
    check("il_m0_rvalid", m0_rvalid, 1);
    check("il_m0_rdata", m0_rdata, 8'hA5);
    check("il_m1_no_rvalid", m1_rvalid, 0);
    tick();
    set1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set0(1'b1, 1'b0, 16'h0030, 8'h00);
    settle();
    check("il_m0_gnt2", m0_gnt, 1);
    check("il_no_rvalid0", m0_rvalid, 0);
    check("il_no_rvalid1", m1_rvalid, 0);
    tick();
    set0(1'b0, 1'b0, 16'h0, 8'h0);
    settle();
    check("il_m0_rvalid2", m0_rvalid, 1);
    check("il_m0_rdata2", m0_rdata, 8'h55);
    check("il_m1_rvalid2", m1_rvalid, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
